// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states, request payload.
package mem_ctrl_pkg;

  localparam int unsigned MEM_WORD_BYTES = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Bytes touched by a size code; 0 marks an illegal code.
  function automatic logic [2:0] size_nbytes(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: size_nbytes = 3'd1;
      SZ_H, SZ_HU: size_nbytes = 3'd2;
      SZ_W:        size_nbytes = 3'(MEM_WORD_BYTES);
      default:     size_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester-side handshake and response bus of mem_access_ctrl, all ports packed side by side.
interface mem_access_ctrl_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*3-1:0]  req_size;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid port after last_grant wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant_i) + off) % NUM_REQ);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrated load/store sequencer for the byte-addressed data memory (read-merge-write stores,
// load extension). Define MEM_ACCESS_MISALIGN_TRAP_EN to flag misaligned H/W accesses as errors.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter logic [31:0] ADDR_LIMIT = 32'h0001FFFF
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic [IDX_W-1:0]   id_q, id_d, last_q, last_d, grant_idx;
  logic [NUM_REQ-1:0] grant, rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d, load_ext, store_merge;
  logic               rsp_err_q, rsp_err_d, err, misalign;
  logic [2:0]         nbytes;
  logic [32:0]        end_addr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .valid_i      (bus.req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .idx_o        (grant_idx)
  );

  // Range, size-code and (optionally) alignment check on the latched request
  always_comb begin
    nbytes   = size_nbytes(req_q.size);
    end_addr = {1'b0, req_q.addr} + 33'(nbytes) - 33'd1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign = ((req_q.size == SZ_H || req_q.size == SZ_HU) && req_q.addr[0]) ||
               ((req_q.size == SZ_W) && (req_q.addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    err = (nbytes == 3'd0) || (end_addr > {1'b0, ADDR_LIMIT}) || misalign;
  end

  // Load extension and store merge; untouched bytes keep their current memory value
  always_comb begin
    load_ext    = '0;
    store_merge = mem_rd;
    case (req_q.size)
      SZ_B:  load_ext = {{24{mem_rd[7]}}, mem_rd[7:0]};
      SZ_BU: load_ext = {24'd0, mem_rd[7:0]};
      SZ_H:  load_ext = {{16{mem_rd[15]}}, mem_rd[15:0]};
      SZ_HU: load_ext = {16'd0, mem_rd[15:0]};
      SZ_W:  load_ext = mem_rd;
      default: load_ext = '0;
    endcase
    case (req_q.size)
      SZ_B, SZ_BU: store_merge = {mem_rd[31:8], req_q.wdata[7:0]};
      SZ_H, SZ_HU: store_merge = {mem_rd[31:16], req_q.wdata[15:0]};
      SZ_W:        store_merge = req_q.wdata;
      default:     store_merge = mem_rd;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    id_d          = id_q;
    last_d        = last_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    bus.req_ready = '0;
    mem_we        = 1'b0;
    mem_wd        = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          bus.req_ready = grant;
        end
        if (|grant) begin
          req_d.we    = bus.req_we[grant_idx];
          req_d.size  = bus.req_size[3*grant_idx +: 3];
          req_d.addr  = bus.req_addr[32*grant_idx +: 32];
          req_d.wdata = bus.req_wdata[32*grant_idx +: 32];
          id_d        = grant_idx;
          last_d      = grant_idx;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          mem_we = !err;
          mem_wd = store_merge;
        end
        rsp_valid_d[id_q] = 1'b1;
        rsp_err_d         = err;
        rsp_rdata_d       = (req_q.we || err) ? 32'd0 : load_ext;
        state_d           = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      id_q        <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_a         = req_q.addr;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single transactions plus hand-written
// arbitration and reset-in-ACCESS sequences against a byte-array memory model.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned MEM_BYTES = 32'h20004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  mem_access_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

  mem_access_ctrl #(.NUM_REQ(NUM_REQ), .ADDR_LIMIT(32'h0001FFFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [MEM_BYTES];

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (mem_a + 32'(i) < MEM_BYTES) mem_rd[8*i +: 8] = mem[mem_a + 32'(i)];
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_a + 32'(i) < MEM_BYTES) mem[mem_a + 32'(i)] <= mem_wd[8*i +: 8];
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  // One request on one port; entered and left at a negedge.
  task automatic run_txn(input string tag, input vec_t v);
    bit                 accepted = 1'b0;
    int                 waitc = 0;
    logic               seen_we;
    logic [NUM_REQ-1:0] exp_oh = '0;
    exp_oh[v.port] = 1'b1;
    bus.req_we[v.port]              = v.we;
    bus.req_size[v.port*3 +: 3]     = v.size;
    bus.req_addr[v.port*32 +: 32]   = v.addr;
    bus.req_wdata[v.port*32 +: 32]  = v.wdata;
    bus.req_valid[v.port]           = 1'b1;
    while (!accepted && waitc < 20) begin
      #1;
      accepted = bus.req_ready[v.port];
      @(negedge clk);
      waitc++;
    end
    bus.req_valid[v.port] = 1'b0;
    if (!accepted) begin
      chk({tag, " accept timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " ready low in ACCESS"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " no rsp in ACCESS"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " mem_a"}, mem_a, v.addr);
    seen_we = mem_we;
    @(negedge clk);
    chk({tag, " rsp_valid owner"}, 32'(bus.rsp_valid), 32'(exp_oh));
    chk({tag, " rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({tag, " mem_we"}, 32'(seen_we), 32'(v.we && !v.exp_err));
    @(negedge clk);
    chk({tag, " rsp pulse ends"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          grants, resps, cyc, exp_owner;
    logic [1:0]  r, exp_g, exp_rv;
    logic [31:0] arb_rdata [2];
    vec_t        v;

    vecs[0]  = '{0, 1'b1, SZ_W,  32'h100,   32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{0, 1'b0, SZ_W,  32'h100,   32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b1, SZ_B,  32'h101,   32'h000000AB, 32'h0, 1'b0};
    vecs[3]  = '{0, 1'b0, SZ_W,  32'h100,   32'h0, 32'hDEADABEF, 1'b0};
    vecs[4]  = '{0, 1'b0, SZ_B,  32'h101,   32'h0, 32'hFFFFFFAB, 1'b0};
    vecs[5]  = '{0, 1'b0, SZ_BU, 32'h101,   32'h0, 32'h000000AB, 1'b0};
    vecs[6]  = '{1, 1'b0, SZ_H,  32'h100,   32'h0, 32'hFFFFABEF, 1'b0};
    vecs[7]  = '{1, 1'b0, SZ_HU, 32'h102,   32'h0, 32'h0000DEAD, 1'b0};
    vecs[8]  = '{1, 1'b1, SZ_H,  32'h102,   32'hFFFF1234, 32'h0, 1'b0};
    vecs[9]  = '{0, 1'b0, SZ_W,  32'h100,   32'h0, 32'h1234ABEF, 1'b0};
    vecs[10] = '{0, 1'b1, SZ_W,  32'h104,   32'h000000F0, 32'h0, 1'b0};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    vecs[11] = '{0, 1'b0, SZ_H,  32'h103,   32'h0, 32'h0, 1'b1};
`else
    vecs[11] = '{0, 1'b0, SZ_H,  32'h103,   32'h0, 32'hFFFFF012, 1'b0};
`endif
    vecs[12] = '{0, 1'b0, SZ_W,  32'h1FFFE, 32'h0, 32'h0, 1'b1};
    vecs[13] = '{0, 1'b1, SZ_W,  32'h20000, 32'h11111111, 32'h0, 1'b1};
    vecs[14] = '{1, 1'b1, SZ_B,  32'h1FFFF, 32'h0000005A, 32'h0, 1'b0};
    vecs[15] = '{1, 1'b0, SZ_BU, 32'h1FFFF, 32'h0, 32'h0000005A, 1'b0};
    vecs[16] = '{1, 1'b0, SZ_H,  32'h1FFFF, 32'h0, 32'h0, 1'b1};
    vecs[17] = '{0, 1'b1, 3'b011, 32'h300,  32'hAAAAAAAA, 32'h0, 1'b1};
    vecs[18] = '{0, 1'b0, SZ_W,  32'h300,   32'h0, 32'h0, 1'b0};
    vecs[19] = '{1, 1'b0, SZ_W,  32'h1FFFC, 32'h0, 32'h5A000000, 1'b0};

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_size  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values, with requests pending to show ready stays low under reset
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_a", mem_a, 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("first winner after reset", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Both ports held valid: strict alternation starting at port 0 (port 1 was served last)
    arb_rdata[0] = 32'h1234ABEF;
    arb_rdata[1] = 32'h000000F0;
    bus.req_we    = 2'b00;
    bus.req_size  = {SZ_W, SZ_W};
    bus.req_addr  = {32'h104, 32'h100};
    bus.req_valid = 2'b11;
    grants = 0; resps = 0; cyc = 0; exp_owner = 0;
    while (resps < 6 && cyc < 60) begin
      #1;
      if (bus.rsp_valid != '0) begin
        exp_rv = '0;
        exp_rv[exp_owner] = 1'b1;
        chk($sformatf("arb rsp%0d owner", resps), 32'(bus.rsp_valid), 32'(exp_rv));
        chk($sformatf("arb rsp%0d rdata", resps), bus.rsp_rdata, arb_rdata[exp_owner]);
        resps++;
      end
      r = bus.req_ready;
      chk("arb ready at most one-hot", 32'($countones(r) <= 1), 32'd1);
      if (r != '0) begin
        exp_g = (grants % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("arb grant%0d", grants), 32'(r), 32'(exp_g));
        exp_owner = grants % 2;
        grants++;
      end
      if (resps < 6) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.req_valid = '0;
    chk("arb grant count", 32'(grants), 32'd6);
    chk("arb response count", 32'(resps), 32'd6);
    @(negedge clk);

    // Reset while a store sits in ACCESS: the write and its response are dropped
    v = '{0, 1'b1, SZ_W, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0};
    run_txn("prior SW 0x200", v);
    bus.req_we[0]          = 1'b1;
    bus.req_size[2:0]      = SZ_W;
    bus.req_addr[31:0]     = 32'h200;
    bus.req_wdata[31:0]    = 32'h12345678;
    bus.req_valid[0]       = 1'b1;
    #1;
    chk("rst seq accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    chk("rst seq mem_we before reset", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst seq mem_we drops", 32'(mem_we), 32'd0);
    chk("rst seq mem_a cleared", mem_a, 32'd0);
    chk("rst seq rdata cleared", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst seq no rsp %0d", i), 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    v = '{0, 1'b0, SZ_W, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0};
    run_txn("LW 0x200 after reset", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Arbitrates and sequences access to the byte-addressed 32-bit data memory.
  - The memory has a combinational read port and a synchronous whole-word write port.
- Accepts load/store requests from NUM_REQ requesters (port 0 = CPU load/store unit, port 1 = loader/debug) using round-robin arbitration.
- Implements byte/halfword stores as a single-access read-merge-write.
- Implements sign/zero extension for loads.
- Sits between the CPU datapath and the data memory instance.

Parameters:
- NUM_REQ, 2, number of requesters (≥1).
- ADDR_LIMIT, 32'h0001FFFF, highest valid byte address of the memory.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-port request valid
- req_ready  out  NUM_REQ  per-port accept; one-hot or zero
- req_we  in  NUM_REQ  1 = store, 0 = load
- req_size  in  NUM_REQ*3  per-port size code (see package)
- req_addr  in  NUM_REQ*32  per-port byte address
- req_wdata  in  NUM_REQ*32  per-port store data, right-aligned
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning port
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid; range/alignment error
- mem_we  out  1  memory write enable
- mem_a  out  32  memory byte address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory combinational read data, bytes A+3..A

Behaviour:
- Single clock. Reset is asynchronous, active-high.
- Reset values:
  - state = IDLE
  - req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd = 0
  - last_grant = NUM_REQ-1, so port 0 wins first.
- FSM states: IDLE → ACCESS → RESP → IDLE.
- IDLE:
  - req_ready is asserted combinationally for exactly one winner: the first valid port after last_grant in round-robin order. Zero if no port is valid.
  - Handshake is valid & ready at a clock edge. On handshake, latch id/we/size/addr/wdata, update last_grant, go to ACCESS.
  - Requesters hold their request until accepted.
- ACCESS:
  - mem_a = latched addr.
  - Error check: err = (addr + nbytes - 1 > ADDR_LIMIT), computed with 33-bit arithmetic so no wrap. nbytes = 1/2/4.
  - Load: capture mem_rd and extract:
    - B: sign-extend rd[7:0]
    - BU: zero-extend rd[7:0]
    - H: sign-extend rd[15:0]
    - HU: zero-extend rd[15:0]
    - W: rd
  - Store: mem_we = !err. mem_wd is:
    - SB: {rd[31:8], wd[7:0]}
    - SH: {rd[31:16], wd[15:0]}
    - SW: wd
  - Bytes beyond the store width are rewritten with their own current values.
  - Go to RESP.
- RESP:
  - rsp_valid[id] = 1 for one cycle, with rsp_rdata and rsp_err.
  - On error, rsp_rdata = 0. mem_we = 0. Go to IDLE.
- Latency: request accepted at edge N; memory written at edge N+1; rsp_valid high in cycle N+2. Throughput is one access per 3 cycles.
- Illegal size code: treated as an error, no memory write.
- Reset mid-operation: immediate return to IDLE with all outputs forced to 0.
  - A store in ACCESS without a completing edge is not performed.
  - No response is issued for a dropped request.
- rsp_rdata is held between responses. mem_a holds the last latched address outside ACCESS.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0, are errors.
  - No memory write occurs and rsp_err = 1.
- Undefined:
  - Misaligned accesses are performed as byte-addressed accesses starting at addr.

Decomposition:
- Package mem_ctrl_pkg holds:
  - size enum: SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101
  - state enum: IDLE/ACCESS/RESP
  - localparam MEM_WORD_BYTES = 4
- One sub-module, rr_arbiter (NUM_REQ):
  - inputs: valid vector, last_grant
  - outputs: one-hot grant and index
  - purely combinational

Test Plan:
- SW port0 addr 0x100 wd 0xDEADBEEF, then LW 0x100 → rdata 0xDEADBEEF. rsp_valid[0] exactly 2 cycles after each accept; rsp_err = 0.
- SB 0xAB at 0x101 over the above, then LW 0x100 → 0xDEADABEF; LB 0x101 → 0xFFFFFFAB; LBU 0x101 → 0x000000AB.
- Both ports valid continuously for 6 requests → grants 0,1,0,1,0,1. Each rsp_valid goes only to the owner; req_ready never has two bits set.
- LW 0x0001FFFE → rsp_err = 1, rdata = 0. SW 0x00020000 → rsp_err = 1, mem_we never asserted.
- SW 0x200 wd 0x12345678 with rst pulsed during ACCESS → mem_we falls immediately, no rsp_valid, later LW 0x200 returns the prior contents.
- LH 0x103:
  - with macro → rsp_err = 1
  - without macro → sign-extended {mem[0x104], mem[0x103]}, rsp_err = 0
